// File: rtl/fd_mon_pkg.sv
// Shared types and helpers for the frequency monitors.
//   fd_state_e  : measurement FSM states
//   fd_cmp_t    : fast/slow verdict of one window
//   fd_compare  : classify a window count against target +/- tolerance
package fd_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } fd_state_e;

   localparam int FD_CNT_W_DEF = 10;

   typedef struct packed {
      logic fast;
      logic slow;
   } fd_cmp_t;

   // One bit wider than the operands so target+tol and meas+tol never wrap.
   function automatic fd_cmp_t fd_compare(input logic [31:0] meas,
                                          input logic [31:0] target,
                                          input logic [31:0] tol);
      logic [32:0] hi_lim;
      logic [32:0] meas_tol;
      fd_cmp_t     res;
      hi_lim   = {1'b0, target} + {1'b0, tol};
      meas_tol = {1'b0, meas} + {1'b0, tol};
      res.fast = ({1'b0, meas} > hi_lim);
      res.slow = (meas_tol < {1'b0, target});
      return res;
   endfunction

endpackage

// File: rtl/fd_sync_edge.sv
// 2-FF synchronizer followed by a rising-edge detector.
//   clk  : destination clock
//   rst  : synchronous active-high reset
//   din  : asynchronous input
//   rise : one-cycle pulse per synchronized rising edge of din
module fd_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic sync3;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise = sync2 & ~sync3;

endmodule

// File: rtl/fd_freq_monitor.sv
// Divided-clock frequency monitor: counts rising edges of div_in over a window
// of WIN_LEN clk cycles, compares against target and tracks lock.
//   clk, rst    : reference clock, synchronous active-high reset
//   en          : measurement enable
//   div_in      : divided clock under test (asynchronous)
//   target      : expected edges per window, sampled at window close
//   meas_cnt    : edge count of last completed window
//   meas_valid  : one-cycle pulse when meas_cnt/fast/slow update
//   fast, slow  : last window above / below tolerance band
//   locked      : LOCK_CNT consecutive in-tolerance windows
//
// state   | meaning
// IDLE    | disabled, counters cleared, meas_cnt held
// ARM     | first window after enable, result discarded while sync pipe fills
// MEASURE | every window close publishes a result
module fd_freq_monitor
   import fd_mon_pkg::*;
#(
   parameter int WIN_LEN  = 256,
   parameter int CNT_W    = FD_CNT_W_DEF,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_in,
   input  logic [CNT_W-1:0] target,
   output logic [CNT_W-1:0] meas_cnt,
   output logic             meas_valid,
   output logic             fast,
   output logic             slow,
   output logic             locked
);

   localparam int WIN_W   = $clog2(WIN_LEN);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   fd_state_e          state;
   logic [WIN_W-1:0]   win_cnt;
   logic [CNT_W-1:0]   edge_cnt;
   logic [MATCH_W-1:0] match_cnt;
   logic               div_rise;
   logic               win_close;
   logic [CNT_W-1:0]   edge_total;
   logic [MATCH_W-1:0] match_next;
   fd_cmp_t            cmp;
   logic               in_tol;

   fd_sync_edge u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (div_in),
      .rise (div_rise)
   );

   assign win_close = (win_cnt == WIN_W'(WIN_LEN - 1));

   // Includes an edge seen in the current cycle, so a close-cycle edge lands
   // in the closing window.
   assign edge_total = (edge_cnt == CNT_MAX) ? CNT_MAX : edge_cnt + CNT_W'(div_rise);

   assign cmp        = fd_compare(32'(edge_total), 32'(target), 32'(TOL));
   assign in_tol     = ~cmp.fast & ~cmp.slow;
   assign match_next = (match_cnt == MATCH_W'(LOCK_CNT)) ? match_cnt
                                                          : match_cnt + MATCH_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         win_cnt    <= '0;
         edge_cnt   <= '0;
         match_cnt  <= '0;
         meas_cnt   <= '0;
         meas_valid <= 1'b0;
         fast       <= 1'b0;
         slow       <= 1'b0;
         locked     <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (!en) begin
            state     <= IDLE;
            win_cnt   <= '0;
            edge_cnt  <= '0;
            match_cnt <= '0;
            fast      <= 1'b0;
            slow      <= 1'b0;
            locked    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= ARM;
                  win_cnt  <= '0;
                  edge_cnt <= '0;
               end
               ARM, MEASURE: begin
                  if (win_close) begin
                     state    <= MEASURE;
                     win_cnt  <= '0;
                     edge_cnt <= '0;
                     if (state == MEASURE) begin
                        meas_cnt   <= edge_total;
                        fast       <= cmp.fast;
                        slow       <= cmp.slow;
                        meas_valid <= 1'b1;
                        if (in_tol) begin
                           match_cnt <= match_next;
                           locked    <= (match_next == MATCH_W'(LOCK_CNT));
                        end else begin
                           match_cnt <= '0;
                           locked    <= 1'b0;
                        end
                     end
                  end else begin
                     win_cnt  <= win_cnt + WIN_W'(1);
                     edge_cnt <= edge_total;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fd_freq_monitor.sv
module tb_fd_freq_monitor;

   localparam int WIN_LEN  = 16;
   localparam int TOL      = 1;
   localparam int LOCK_CNT = 4;

   logic       clk;
   logic       rst;
   logic       en;
   logic       div_in;
   logic [5:0] target;
   logic [2:0] target1;

   logic [5:0] meas_cnt0;
   logic       mv0, fast0, slow0, locked0;
   logic [2:0] meas_cnt1;
   logic       mv1, fast1, slow1, locked1;

   assign target1 = target[2:0];

   fd_freq_monitor #(.WIN_LEN(WIN_LEN), .CNT_W(6), .TOL(TOL), .LOCK_CNT(LOCK_CNT)) dut0 (
      .clk(clk), .rst(rst), .en(en), .div_in(div_in), .target(target),
      .meas_cnt(meas_cnt0), .meas_valid(mv0), .fast(fast0), .slow(slow0), .locked(locked0));

   fd_freq_monitor #(.WIN_LEN(WIN_LEN), .CNT_W(3), .TOL(TOL), .LOCK_CNT(LOCK_CNT)) dut1 (
      .clk(clk), .rst(rst), .en(en), .div_in(div_in), .target(target1),
      .meas_cnt(meas_cnt1), .meas_valid(mv1), .fast(fast1), .slow(slow1), .locked(locked1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- div_in generator ----------------
   int div_mode = 1;   // 0 manual, 1 periodic, 2 random bits
   int div_per  = 4;
   int div_ph   = 0;

   always @(negedge clk) begin
      if (div_mode == 1) begin
         div_ph = (div_ph + 1 >= div_per) ? 0 : div_ph + 1;
         div_in = (div_ph < div_per / 2);
      end else if (div_mode == 2) begin
         div_in = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- reference model ----------------
   // An edge sampled high at posedge n-2 after low at n-3 is counted at posedge n.
   typedef struct {
      int cnt;
      bit fast;
      bit slow;
      bit locked;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int h1 = 0, h2 = 0, h3 = 0;
   bit m_active[2], m_armed[2], m_valid[2];
   bit m_fast[2], m_slow[2], m_locked[2];
   int m_pos[2], m_acc[2], m_meas[2], m_run[2];
   int m_max[2] = '{63, 7};

   always @(posedge clk) begin
      int e;
      e = (h2 == 1 && h3 == 0) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
         int   tgt;
         int   tot;
         exp_t x;
         m_valid[i] = 0;
         tgt = (i == 0) ? int'(target) : int'(target) % 8;
         if (rst) begin
            m_active[i] = 0; m_meas[i] = 0; m_run[i] = 0;
            m_fast[i] = 0; m_slow[i] = 0; m_locked[i] = 0;
         end else if (!en) begin
            m_active[i] = 0; m_run[i] = 0;
            m_fast[i] = 0; m_slow[i] = 0; m_locked[i] = 0;
         end else if (!m_active[i]) begin
            m_active[i] = 1; m_armed[i] = 0; m_pos[i] = 0; m_acc[i] = 0;
         end else if (m_pos[i] == WIN_LEN - 1) begin
            tot = (m_acc[i] + e > m_max[i]) ? m_max[i] : m_acc[i] + e;
            if (m_armed[i]) begin
               m_meas[i] = tot;
               m_fast[i] = (tot > tgt + TOL);
               m_slow[i] = (tot + TOL < tgt);
               if (!m_fast[i] && !m_slow[i]) m_run[i]++;
               else m_run[i] = 0;
               m_locked[i] = (m_run[i] >= LOCK_CNT);
               m_valid[i]  = 1;
               x.cnt = tot; x.fast = m_fast[i]; x.slow = m_slow[i]; x.locked = m_locked[i];
               if (i == 0) q0.push_back(x);
               else q1.push_back(x);
            end
            m_armed[i] = 1; m_acc[i] = 0; m_pos[i] = 0;
         end else begin
            m_acc[i] = (m_acc[i] + e > m_max[i]) ? m_max[i] : m_acc[i] + e;
            m_pos[i]++;
         end
      end
      h3 = h2; h2 = h1; h1 = int'(div_in);
      if (rst) begin h1 = 0; h2 = 0; h3 = 0; end
   end

   // ---------------- monitor / scoreboard ----------------
   bit mon_on = 0;

   always @(negedge clk) begin
      if (mon_on) begin
         for (int i = 0; i < 2; i++) begin
            int   a_cnt;
            bit   a_val, a_fast, a_slow, a_lock;
            exp_t x;
            a_cnt  = (i == 0) ? int'(meas_cnt0) : int'(meas_cnt1);
            a_val  = (i == 0) ? mv0 : mv1;
            a_fast = (i == 0) ? fast0 : fast1;
            a_slow = (i == 0) ? slow0 : slow1;
            a_lock = (i == 0) ? locked0 : locked1;
            checks++;
            if (a_val != m_valid[i]) begin
               errors++;
               $display("FAIL valid[%0d] t=%0t: got %0b expected %0b", i, $time, a_val, m_valid[i]);
            end
            if (a_val) begin
               checks++;
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  errors++;
                  $display("FAIL result[%0d] t=%0t: unexpected meas_valid, nothing expected", i, $time);
               end else begin
                  x = (i == 0) ? q0.pop_front() : q1.pop_front();
                  if (a_cnt != x.cnt || a_fast != x.fast || a_slow != x.slow || a_lock != x.locked) begin
                     errors++;
                     $display("FAIL result[%0d] t=%0t: got cnt=%0d f=%0b s=%0b l=%0b expected cnt=%0d f=%0b s=%0b l=%0b",
                              i, $time, a_cnt, a_fast, a_slow, a_lock, x.cnt, x.fast, x.slow, x.locked);
                  end
               end
            end else begin
               checks++;
               if (a_cnt != m_meas[i] || a_fast != m_fast[i] || a_slow != m_slow[i] || a_lock != m_locked[i]) begin
                  errors++;
                  $display("FAIL hold[%0d] t=%0t: got cnt=%0d f=%0b s=%0b l=%0b expected cnt=%0d f=%0b s=%0b l=%0b",
                           i, $time, a_cnt, a_fast, a_slow, a_lock, m_meas[i], m_fast[i], m_slow[i], m_locked[i]);
               end
            end
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic wait_valid(input int bound, output bit ok);
      ok = 0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (mv0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_valid: no meas_valid within %0d cycles", bound);
      end
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_cnt0"}, int'(meas_cnt0), 0);
      chk({name, "_cnt1"}, int'(meas_cnt1), 0);
      chk({name, "_flags0"}, int'({mv0, fast0, slow0, locked0}), 0);
      chk({name, "_flags1"}, int'({mv1, fast1, slow1, locked1}), 0);
   endtask

   initial begin
      bit ok;
      int held;
      int periods[6] = '{2, 3, 4, 5, 6, 8};

      rst = 1'b1; en = 1'b0; div_in = 1'b0; target = 6'd4;
      repeat (5) @(negedge clk);
      check_all_zero("reset");
      mon_on = 1;
      rst = 1'b0;

      // period 4, target 4: lock with 4th result
      en = 1'b1;
      for (int w = 1; w <= 4; w++) begin
         wait_valid(60, ok);
         chk("lock_cnt", int'(meas_cnt0), 4);
         chk("lock_fs", int'({fast0, slow0}), 0);
         chk("lock_locked", int'(locked0), (w == 4) ? 1 : 0);
      end

      // double frequency: fast, lock lost; narrow instance saturates
      div_per = 2;
      wait_valid(40, ok);
      wait_valid(40, ok);
      chk("fast_cnt", int'(meas_cnt0), 8);
      chk("fast_flag", int'(fast0), 1);
      chk("fast_locked", int'(locked0), 0);
      chk("sat_cnt1", int'(meas_cnt1), 7);
      chk("sat_fast1", int'(fast1), 1);

      // re-lock, then drop enable mid-window
      div_per = 4;
      repeat (5) wait_valid(40, ok);
      chk("relock", int'(locked0), 1);
      held = int'(meas_cnt0);
      repeat (5) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("idle_flags", int'({mv0, fast0, slow0, locked0}), 0);
      chk("idle_held", int'(meas_cnt0), held);
      repeat (3) @(negedge clk);
      en = 1'b1;
      for (int w = 1; w <= 4; w++) begin
         wait_valid(60, ok);
         chk("reen_locked", int'(locked0), (w == 4) ? 1 : 0);
      end

      // div_in held low
      div_mode = 0; div_in = 1'b0; target = 6'd3;
      wait_valid(40, ok);
      wait_valid(40, ok);
      chk("low_cnt", int'(meas_cnt0), 0);
      chk("low_slow", int'(slow0), 1);
      chk("low_locked", int'(locked0), 0);
      target = 6'd1;
      wait_valid(40, ok);
      wait_valid(40, ok);
      chk("low_tol", int'({fast0, slow0}), 0);

      // single edge counted exactly in the window-close cycle
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (m_active[0] && m_armed[0] && m_pos[0] == WIN_LEN - 3) begin
            ok = 1;
            break;
         end
      end
      chk("align_found", int'(ok), 1);
      div_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      div_in = 1'b0;
      wait_valid(5, ok);
      chk("close_edge_in", int'(meas_cnt0), 1);
      wait_valid(40, ok);
      chk("close_edge_next", int'(meas_cnt0), 0);

      // reset mid-window while locked
      div_mode = 1; div_per = 4; target = 6'd4;
      repeat (6) wait_valid(40, ok);
      chk("pre_rst_locked", int'(locked0), 1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midrst");
      rst = 1'b0;

      // randomized segments
      for (int seg = 0; seg < 40; seg++) begin
         int len;
         if ($urandom_range(0, 4) == 0) div_mode = 2;
         else begin
            div_mode = 1;
            div_per  = periods[$urandom_range(0, 5)];
         end
         target = 6'($urandom_range(0, 10));
         len = $urandom_range(20, 150);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            en  = ($urandom_range(0, 299) != 0);
            rst = ($urandom_range(0, 499) == 0);
         end
      end
      rst = 1'b0; en = 1'b0;
      repeat (5) @(negedge clk);
      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
